// File: rtl/debounce_pkg.sv
// Shared constants and threshold selection for the switch/sensor debouncer.
// Latency: n/a (compile-time helpers only).
// Backpressure: n/a.
package debounce_pkg;

    // Width of the short stability window used for fast simulation builds.
    localparam int FAST_THRESH_W = 9;

    // Stability threshold: all-ones of the fast window or of the full counter.
    // Computed in 64 bits so CNT_W up to 32 does not overflow the shift.
    function automatic logic [63:0] thresh_sel(input bit fast_sim, input int cnt_w);
        if (fast_sim) begin
            return (64'd1 << FAST_THRESH_W) - 64'd1;
        end
        return (64'd1 << cnt_w) - 64'd1;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 3-flop synchroniser, saturating stable counter, filtered level + edge pulses.
// Latency: level captured at edge E appears on sig_filt (with its edge pulse) at edge E+THRESH+3.
// Backpressure: none; free-running, one sample per clock.
//
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   sig_in           : raw asynchronous input
//   sig_filt         : debounced level
//   filt_rise/fall   : registered one-cycle pulses coincident with a sig_filt change
//   raw_rise         : combinational rising edge of the synchronised, unfiltered input
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int FAST_SIM = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic sig_filt,
    output logic filt_rise,
    output logic filt_fall,
    output logic raw_rise
);

    localparam logic [CNT_W-1:0] THRESH = CNT_W'(thresh_sel(FAST_SIM != 0, CNT_W));

    logic             s1;
    logic             s2;
    logic             s3;
    logic [CNT_W-1:0] cnt;
    logic             chg;
    logic             at_thresh;
    logic             load;

    // s1 is the metastability flop; s2/s3 are a clean adjacent-sample pair.
    assign chg       = s2 ^ s3;
    assign at_thresh = (cnt == THRESH);
    assign load      = at_thresh & ~chg & (s3 ^ sig_filt);
    assign raw_rise  = s2 & ~s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            cnt       <= '0;
            sig_filt  <= 1'b0;
            filt_rise <= 1'b0;
            filt_fall <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;

            // Any disagreement restarts the window; otherwise count up and hold at THRESH.
            if (chg) begin
                cnt <= '0;
            end else if (!at_thresh) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (load) begin
                sig_filt <= s3;
            end
            // Pulses are registered alongside sig_filt so they line up with its new value.
            filt_rise <= load & s3;
            filt_fall <= load & ~s3;
        end
    end

endmodule

// File: rtl/multi_chan_debounce.sv
// N_CH independent debounce channels for cadence/hall/brake inputs.
// Latency: input held from capture edge E -> sig_filt and filt pulse at edge E+THRESH+3.
// Backpressure: none; every channel samples every clock.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   sig_in      : raw asynchronous inputs, one bit per channel
//   sig_filt    : debounced levels
//   filt_rise   : one-cycle pulse on a 0->1 change of sig_filt
//   filt_fall   : one-cycle pulse on a 1->0 change of sig_filt
//   raw_rise    : combinational rising edge of the synchronised, unfiltered inputs
module multi_chan_debounce
    import debounce_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int CNT_W    = 16,
    parameter int FAST_SIM = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] sig_in,
    output logic [N_CH-1:0] sig_filt,
    output logic [N_CH-1:0] filt_rise,
    output logic [N_CH-1:0] filt_fall,
    output logic [N_CH-1:0] raw_rise
);

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        debounce_chan #(
            .CNT_W    (CNT_W),
            .FAST_SIM (FAST_SIM)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .sig_in    (sig_in[i]),
            .sig_filt  (sig_filt[i]),
            .filt_rise (filt_rise[i]),
            .filt_fall (filt_fall[i]),
            .raw_rise  (raw_rise[i])
        );
    end

endmodule

// File: tb/tb_multi_chan_debounce.sv
// Scoreboard bench: stimulus pushes expected filt-edge events, monitors pop them on every DUT pulse.
// Edge numbering: cyc equals the number of rising edges so far; inputs driven on the falling edge
// are captured into s1 at edge E = cyc+1, so the fast build reports at E+514 and the slow one at E+1026.
module tb_multi_chan_debounce;

    localparam int NCH = 4;

    typedef struct {
        int             cyc;
        logic [NCH-1:0] rise;
        logic [NCH-1:0] fall;
        logic [NCH-1:0] filt;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] sig_in;
    logic [NCH-1:0] sig_filt, filt_rise, filt_fall, raw_rise;
    logic [0:0]     sig_in_s;
    logic [0:0]     sig_filt_s, filt_rise_s, filt_fall_s, raw_rise_s;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   raw1_cnt = 0;
    exp_t q[$];
    exp_t qs[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multi_chan_debounce #(.N_CH(NCH), .CNT_W(16), .FAST_SIM(1)) u_fast (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .sig_filt(sig_filt),
        .filt_rise(filt_rise), .filt_fall(filt_fall), .raw_rise(raw_rise)
    );

    multi_chan_debounce #(.N_CH(1), .CNT_W(10), .FAST_SIM(0)) u_slow (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in_s), .sig_filt(sig_filt_s),
        .filt_rise(filt_rise_s), .filt_fall(filt_fall_s), .raw_rise(raw_rise_s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Fast-DUT monitor: every filt pulse must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (raw_rise[1]) raw1_cnt++;
            if ((filt_rise | filt_fall) != '0) begin
                if (q.size() == 0) begin
                    chk("unexpected_pulse", {filt_rise, filt_fall}, 32'h0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("ev_cycle", cyc, e.cyc);
                    chk("ev_rise", filt_rise, e.rise);
                    chk("ev_fall", filt_fall, e.fall);
                    chk("ev_filt", sig_filt, e.filt);
                end
            end
        end
    end

    // Slow-DUT monitor.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (filt_rise_s | filt_fall_s) != '0) begin
            if (qs.size() == 0) begin
                chk("slow_unexpected_pulse", {filt_rise_s, filt_fall_s}, 32'h0);
            end else begin
                exp_t e;
                e = qs.pop_front();
                chk("slow_ev_cycle", cyc, e.cyc);
                chk("slow_ev_rise", filt_rise_s, e.rise);
                chk("slow_ev_filt", sig_filt_s, e.filt);
            end
        end
    end

    task automatic push(input int c, input logic [NCH-1:0] r, input logic [NCH-1:0] f,
                        input logic [NCH-1:0] v);
        exp_t e;
        e.cyc = c; e.rise = r; e.fall = f; e.filt = v;
        q.push_back(e);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int r0;
        rst_n    = 1'b0;
        sig_in   = '0;
        sig_in_s = '0;

        // Reset state, with inputs high so the sync chain would otherwise move.
        repeat (3) @(negedge clk);
        sig_in = '1;
        repeat (3) @(negedge clk);
        chk("rst_sig_filt", sig_filt, 0);
        chk("rst_filt_rise", filt_rise, 0);
        chk("rst_filt_fall", filt_fall, 0);
        chk("rst_raw_rise", raw_rise, 0);
        sig_in = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Step on channel 0.
        sig_in[0] = 1'b1;
        e = cyc + 1;
        push(e + 514, 4'b0001, 4'b0000, 4'b0001);
        wait_until(e + 513);
        chk("step_before", sig_filt, 4'b0000);
        wait_until(e + 515);
        chk("step_pulse_gone", filt_rise, 4'b0000);
        chk("step_level", sig_filt, 4'b0001);
        chk("step_q_empty", q.size(), 0);

        // 300-cycle glitch on channel 1 is rejected.
        r0 = raw1_cnt;
        sig_in[1] = 1'b1;
        repeat (300) @(negedge clk);
        sig_in[1] = 1'b0;
        repeat (600) @(negedge clk);
        chk("glitch_level", sig_filt, 4'b0001);
        chk("glitch_raw_rise_count", raw1_cnt - r0, 1);

        // 400 high, 5 low, high again: no partial credit from the first run.
        sig_in[2] = 1'b1;
        repeat (400) @(negedge clk);
        sig_in[2] = 1'b0;
        repeat (5) @(negedge clk);
        sig_in[2] = 1'b1;
        e = cyc + 1;
        push(e + 514, 4'b0100, 4'b0000, 4'b0101);
        wait_until(e + 513);
        chk("restart_before", sig_filt, 4'b0001);
        wait_until(e + 520);
        chk("restart_q_empty", q.size(), 0);

        // Bring all high, then drop all on the same cycle.
        sig_in[1] = 1'b1;
        sig_in[3] = 1'b1;
        e = cyc + 1;
        push(e + 514, 4'b1010, 4'b0000, 4'b1111);
        wait_until(e + 520);
        sig_in = '0;
        e = cyc + 1;
        push(e + 514, 4'b0000, 4'b1111, 4'b0000);
        wait_until(e + 513);
        chk("allfall_before", sig_filt, 4'b1111);
        wait_until(e + 520);
        chk("allfall_q_empty", q.size(), 0);

        // Reset 200 cycles into a pending fall on channel 1.
        sig_in = '1;
        e = cyc + 1;
        push(e + 514, 4'b1111, 4'b0000, 4'b1111);
        wait_until(e + 520);
        sig_in[1] = 1'b0;
        repeat (200) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_sig_filt", sig_filt, 4'b0000);
        chk("midrst_filt_rise", filt_rise, 4'b0000);
        chk("midrst_filt_fall", filt_fall, 4'b0000);
        chk("midrst_raw_rise", raw_rise, 4'b0000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        e = cyc + 1;
        push(e + 514, 4'b1101, 4'b0000, 4'b1101);
        wait_until(e + 513);
        chk("postrst_before", sig_filt, 4'b0000);
        wait_until(e + 520);
        chk("postrst_q_empty", q.size(), 0);

        // Full-width threshold build: CNT_W=10 -> 1023+3.
        begin
            exp_t es;
            sig_in_s = 1'b1;
            e = cyc + 1;
            es.cyc = e + 1026; es.rise = 4'b0001; es.fall = 4'b0000; es.filt = 4'b0001;
            qs.push_back(es);
        end
        wait_until(e + 1025);
        chk("slow_before", sig_filt_s, 1'b0);
        wait_until(e + 1030);
        chk("slow_level", sig_filt_s, 1'b1);
        chk("slow_q_empty", qs.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_chan_debounce.md
MULTI_CHAN_DEBOUNCE -- requirements
Module: multi_chan_debounce

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent input channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 16: stable-counter width in normal mode.
REQ-003 SHALL have parameter FAST_SIM, default 1: when 1, the stability threshold is 2^9-1 (511); when 0, it is 2^CNT_W-1.
REQ-004 SHALL have port clk, input, 1: single system clock, rising-edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port sig_in, input, N_CH: raw asynchronous sensor inputs (cadence, hall, brake switches).
REQ-007 SHALL have port sig_filt, output, N_CH: debounced level per channel.
REQ-008 SHALL have port filt_rise, output, N_CH: one-cycle pulse marking a 0->1 change of sig_filt.
REQ-009 SHALL have port filt_fall, output, N_CH: one-cycle pulse marking a 1->0 change of sig_filt.
REQ-010 SHALL have port raw_rise, output, N_CH: combinational rising edge of the synchronised, unfiltered input.

Function
REQ-011 SHALL pass each channel through a 3-flop chain s1<=sig_in, s2<=s1, s3<=s2.
REQ-012 SHALL drive raw_rise[i] = s2[i] & ~s3[i] combinationally.
REQ-013 SHALL keep a per-channel stable counter: chg = s2^s3; chg=1 clears it to 0; chg=0 increments it; it saturates at THRESH and never wraps.
REQ-014 SHALL load sig_filt[i] <= s3[i] on the edge where counter==THRESH, chg=0 and s3!=sig_filt.
REQ-015 SHALL make filt_rise/filt_fall registered and high in exactly the cycle sig_filt first shows its new value, for one cycle only.
REQ-016 SHALL give latency: input level sampled into s1 at edge E and held -> sig_filt changes at edge E+THRESH+3.
REQ-017 SHALL leave sig_filt unchanged for any input pulse shorter than THRESH+1 cycles at s2, with no filt pulse.
REQ-018 SHALL restart the count from 0 on every s2/s3 disagreement during a pending transition; no partial credit is kept.
REQ-019 SHALL treat channels fully independently; simultaneous transitions on several channels SHALL each complete with their own latency.
REQ-020 SHALL never assert filt_rise[i] and filt_fall[i] in the same cycle.

Reset
REQ-021 SHALL asynchronously clear s1, s2, s3, the counters, sig_filt, filt_rise and filt_fall to 0 on rst_n low.
REQ-022 SHALL abort a pending transition on reset mid-operation; after release, a held-high input produces filt_rise at edge E+THRESH+3 counted from release.
REQ-023 SHALL keep raw_rise at 0 while in reset, since s2 = s3 = 0.

Structure
REQ-024 SHALL place FAST_THRESH_W (=9) and the threshold-select function in package debounce_pkg.
REQ-025 SHALL implement one channel as sub-module debounce_chan (sync chain, counter, filt register, edge pulses), instantiated N_CH times via a generate loop.
REQ-026 SHALL size the counter by CNT_W in both modes; FAST_SIM affects only the threshold compare.

Verification
REQ-027 SHALL cover: FAST_SIM=1, sig_in[0] 0->1 held, captured at edge E -> sig_filt[0]=1 and filt_rise[0]=1 at edge E+514; filt_rise[0]=0 at E+515.
REQ-028 SHALL cover: 300-cycle high glitch on sig_in[1] -> sig_filt[1] stays 0; filt_rise[1] never asserts; raw_rise[1] pulses once.
REQ-029 SHALL cover: sig_in[2] high for 400 cycles, low for 5 cycles, high again -> filt change delayed until 511+3 edges after the second rise is captured.
REQ-030 SHALL cover: all N_CH inputs 1->0 on the same cycle after being stable high -> all filt_fall bits pulse together at E+514.
REQ-031 SHALL cover: rst_n asserted 200 cycles into a pending transition -> all outputs 0 immediately; sig_filt=1 at 514 edges after release with input high.
REQ-032 SHALL cover: FAST_SIM=0, CNT_W=10, step input -> sig_filt changes at edge E+1026.
